// File: rtl/mem_bus_ctrl.sv
// Memory bus arbiter: muxes a fetch port and a data port onto one synchronous
// memory. Data wins by default; a starvation counter forces a fetch grant.
module mem_bus_ctrl #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_bw,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic [15:0] MAB,
    output logic [15:0] MDB_wr,
    output logic        MW,
    output logic        BW,
    input  logic [15:0] MDB_rd
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic valid;
        logic src;   // 1 = data port, 0 = fetch port
        logic bw;
        logic hi;
    } pend_t;

    pend_t          pend_q, pend_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           starve_hit;
    logic           rsp_ok;
    logic           unused_bits;

    assign unused_bits = if_addr[0];

    always_comb begin
        starve_hit = if_req && (starve_q == CW'(STARVE_LIMIT));
        d_gnt      = !rst && d_req && !starve_hit;
        if_gnt     = !rst && if_req && !d_gnt;
        d_err      = d_gnt && !d_bw && d_addr[0];
    end

    // Bus drive; everything is derived from the grants so reset idles it too.
    always_comb begin
        MAB    = '0;
        MDB_wr = '0;
        MW     = 1'b0;
        BW     = 1'b0;
        if (if_gnt) begin
            MAB = {if_addr[15:1], 1'b0};
        end else if (d_gnt) begin
            if (d_we) begin
                MAB    = d_bw ? d_addr : {d_addr[15:1], 1'b0};
                MW     = 1'b1;
                BW     = d_bw;
                MDB_wr = d_bw ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;
            end else begin
                MAB = {d_addr[15:1], 1'b0};
            end
        end
    end

    always_comb begin
        pend_d.valid = if_gnt || (d_gnt && !d_we);
        pend_d.src   = d_gnt;
        pend_d.bw    = d_bw;
        pend_d.hi    = d_addr[0];

        starve_d = starve_q;
        if (!if_req || if_gnt)
            starve_d = '0;
        else if (d_gnt && starve_q != CW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            starve_q <= '0;
        end else begin
            pend_q   <= pend_d;
            starve_q <= starve_d;
        end
    end

    // Response lane: memory data arrives the cycle after the grant.
    always_comb begin
        rsp_ok    = pend_q.valid && !rst;
        if_rvalid = rsp_ok && !pend_q.src;
        d_rvalid  = rsp_ok && pend_q.src;
        if_rdata  = if_rvalid ? MDB_rd : '0;
        d_rdata   = '0;
        if (d_rvalid) begin
            if (pend_q.bw)
                d_rdata = pend_q.hi ? {8'h00, MDB_rd[15:8]} : {8'h00, MDB_rd[7:0]};
            else
                d_rdata = MDB_rd;
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus queues expected grants and
// responses, a negedge monitor pops and compares them.
module tb_mem_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, d_bw;
    logic [15:0] if_addr, d_addr, d_wdata, MDB_rd;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, MW, BW;
    logic [15:0] if_rdata, d_rdata, MAB, MDB_wr;

    int total = 0;
    int passed = 0;

    logic [36:0] gq[$];  // {if_gnt,d_gnt,d_err,MW,BW,MAB,MDB_wr}
    logic [33:0] rq[$];  // {if_rvalid,d_rvalid,if_rdata,d_rdata}
    logic [36:0] g_exp;
    logic [33:0] r_exp;

    mem_bus_ctrl #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_bw(d_bw), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .MAB(MAB), .MDB_wr(MDB_wr), .MW(MW), .BW(BW), .MDB_rd(MDB_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {if_gnt, d_gnt, d_err, MW, BW, MAB, MDB_wr,
                                  if_rvalid, d_rvalid, if_rdata, d_rdata}, 64'd0);
        end else begin
            if (if_gnt || d_gnt) begin
                if (gq.size() == 0) chk("unexpected_grant", {62'd0, if_gnt, d_gnt}, 64'd0);
                else begin
                    g_exp = gq.pop_front();
                    chk("grant", {27'd0, if_gnt, d_gnt, d_err, MW, BW, MAB, MDB_wr}, {27'd0, g_exp});
                end
            end else if (gq.size() != 0) begin
                g_exp = gq.pop_front();
                chk("missing_grant", {27'd0, 2'b00, d_err, MW, BW, MAB, MDB_wr}, {27'd0, g_exp});
            end else begin
                chk("idle_bus", {29'd0, d_err, MW, BW, MAB, MDB_wr}, 64'd0);
            end
            if (if_rvalid || d_rvalid) begin
                if (rq.size() == 0) chk("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
                else begin
                    r_exp = rq.pop_front();
                    chk("response", {30'd0, if_rvalid, d_rvalid, if_rdata, d_rdata}, {30'd0, r_exp});
                end
            end else begin
                chk("idle_rdata", {32'd0, if_rdata, d_rdata}, 64'd0);
            end
        end
    end

    task automatic clr();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_bw = 0; d_addr = '0; d_wdata = '0;
    endtask
    task automatic drv_f(input logic [15:0] a);
        if_req = 1; if_addr = a;
    endtask
    task automatic drv_d(input logic we, input logic bw, input logic [15:0] a, input logic [15:0] wd);
        d_req = 1; d_we = we; d_bw = bw; d_addr = a; d_wdata = wd;
    endtask
    task automatic tick(input logic [15:0] mdb);
        MDB_rd = mdb;
        @(posedge clk); #1;
    endtask
    task automatic eg(input logic f, input logic d, input logic e, input logic mw,
                      input logic bw, input logic [15:0] mab, input logic [15:0] wr);
        gq.push_back({f, d, e, mw, bw, mab, wr});
    endtask
    task automatic er(input logic f, input logic d, input logic [15:0] fr, input logic [15:0] dr);
        rq.push_back({f, d, fr, dr});
    endtask

    initial begin
        clr(); rst = 1; MDB_rd = '0;
        // Requests held during reset must not be granted.
        drv_f(16'h1234); drv_d(0, 0, 16'h2222, 16'h0);
        tick(16'hFFFF); tick(16'hFFFF); tick(16'hFFFF);
        rst = 0; clr();
        tick(16'h0);

        // Fetch, then byte read (back-to-back), then byte write.
        drv_f(16'hC001); eg(1, 0, 0, 0, 0, 16'hC000, 16'h0); er(1, 0, 16'h4031, 16'h0);
        tick(16'h0);
        clr(); drv_d(0, 1, 16'h0201, 16'h0); eg(0, 1, 0, 0, 0, 16'h0200, 16'h0); er(0, 1, 16'h0, 16'h00AB);
        tick(16'h4031);
        clr(); drv_d(1, 1, 16'h0203, 16'h0055); eg(0, 1, 0, 1, 1, 16'h0203, 16'h5555);
        tick(16'hAB12);
        clr(); tick(16'hFFFF);

        // Misaligned word read, low-byte read, misaligned word write.
        drv_d(0, 0, 16'h0211, 16'h0); eg(0, 1, 1, 0, 0, 16'h0210, 16'h0); er(0, 1, 16'h0, 16'h1234);
        tick(16'h0);
        clr(); drv_d(0, 1, 16'h0400, 16'h0); eg(0, 1, 0, 0, 0, 16'h0400, 16'h0); er(0, 1, 16'h0, 16'h0088);
        tick(16'h1234);
        clr(); drv_d(1, 0, 16'h0305, 16'hBEEF); eg(0, 1, 1, 1, 0, 16'h0304, 16'hBEEF);
        tick(16'h7788);
        clr(); tick(16'h0);

        // Starvation: both held 5 cycles -> D,D,D,F,D.
        drv_f(16'h0100); drv_d(0, 0, 16'h0300, 16'h0);
        eg(0, 1, 0, 0, 0, 16'h0300, 16'h0); er(0, 1, 16'h0, 16'h1111); tick(16'h0);
        eg(0, 1, 0, 0, 0, 16'h0300, 16'h0); er(0, 1, 16'h0, 16'h2222); tick(16'h1111);
        eg(0, 1, 0, 0, 0, 16'h0300, 16'h0); er(0, 1, 16'h0, 16'h3333); tick(16'h2222);
        eg(1, 0, 0, 0, 0, 16'h0100, 16'h0); er(1, 0, 16'h4444, 16'h0); tick(16'h3333);
        eg(0, 1, 0, 0, 0, 16'h0300, 16'h0); er(0, 1, 16'h0, 16'h5555); tick(16'h4444);
        clr(); tick(16'h5555);

        // Counter clears when the fetch request drops: D,D,(D alone),D,D,D,F.
        drv_d(1, 0, 16'h0500, 16'h0A0A);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) if_req = 0; else drv_f(16'h0600);
            if (i == 6) begin
                eg(1, 0, 0, 0, 0, 16'h0600, 16'h0); er(1, 0, 16'h9999, 16'h0);
            end else eg(0, 1, 0, 1, 0, 16'h0500, 16'h0A0A);
            tick(16'h0);
        end
        clr(); tick(16'h9999);

        // Read granted, then reset: the response must be suppressed.
        drv_d(0, 0, 16'h0700, 16'h0); eg(0, 1, 0, 0, 0, 16'h0700, 16'h0);
        tick(16'h0);
        rst = 1; drv_f(16'h0900);
        tick(16'hDEAD); tick(16'hDEAD);
        rst = 0; clr();
        // First grant in the cycle right after reset falls.
        drv_d(0, 0, 16'h0800, 16'h0); eg(0, 1, 0, 0, 0, 16'h0800, 16'h0); er(0, 1, 16'h0, 16'h0123);
        tick(16'h0);
        clr(); tick(16'h0123);
        tick(16'h0);

        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, max consecutive data grants while a fetch request waits.
REQ-002 clk  input  1  rising-edge clock; one clock for the whole block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch read request, held until granted.
REQ-005 if_addr  input  16  fetch byte address; bit 0 ignored.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch read data valid.
REQ-008 if_rdata  output  16  fetch read word.
REQ-009 d_req  input  1  data access request, held until granted.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_bw  input  1  1 = byte access, 0 = word access.
REQ-012 d_addr  input  16  data byte address.
REQ-013 d_wdata  input  16  write data; byte writes use bits 7:0.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  data read data valid.
REQ-016 d_rdata  output  16  data read result, zero-extended for byte reads.
REQ-017 d_err  output  1  misaligned word access flag, one cycle with d_gnt.
REQ-018 MAB  output  16  address to memory space MAB_in.
REQ-019 MDB_wr  output  16  write data to memory space MDB_in.
REQ-020 MW  output  1  memory write strobe to memory space MW.
REQ-021 BW  output  1  byte-write flag to memory space BW.
REQ-022 MDB_rd  input  16  memory read word from memory space MDB_out, valid one cycle after the address.

Function
REQ-023 At most one grant per cycle; grants are combinational from the current requests and state.
REQ-024 Arbitration: data has priority over fetch, except when starve_cnt == STARVE_LIMIT and if_req=1, in which case fetch is granted.
REQ-025 starve_cnt increments on each d_gnt while if_req=1, clears on if_gnt or when if_req=0, and saturates at STARVE_LIMIT.
REQ-026 Granted fetch: MAB = {if_addr[15:1],0}; MW=0; BW=0.
REQ-027 Granted data read: MAB = {d_addr[15:1],0}; MW=0; BW=0.
REQ-028 Granted data write: MAB = d_addr (word writes force bit 0 to 0); MW=1; BW=d_bw; MDB_wr = d_bw ? {d_wdata[7:0],d_wdata[7:0]} : d_wdata.
REQ-029 No grant: MAB=0, MDB_wr=0, MW=0, BW=0.
REQ-030 Each read grant registers a pending record {valid, src, byte, hi=addr[0]}.
REQ-031 The cycle after a read grant, the matching rvalid is 1 for exactly one cycle, with rdata taken from MDB_rd in that cycle.
REQ-032 Byte read result: hi ? {8'h00,MDB_rd[15:8]} : {8'h00,MDB_rd[7:0]}.
REQ-033 Word read result: MDB_rd unchanged.
REQ-034 Writes produce no rvalid.
REQ-035 Back-to-back reads are legal: a new grant and the previous response occur in the same cycle.
REQ-036 Word data access with d_addr[0]=1: still performed at the even address, with d_err=1 in the grant cycle.
REQ-037 Simultaneous if_req and d_req below the starvation limit: d_gnt=1 and if_gnt=0; the fetch stays pending.
REQ-038 rvalid and rdata of the unselected source: 0.

Reset
REQ-039 While rst=1: no grants; pending record cleared; starve_cnt=0; all outputs 0.
REQ-040 A read granted in the cycle before rst asserts produces no rvalid.
REQ-041 The first grant is possible in the cycle after rst deasserts.

Verification
REQ-042 Fetch if_addr=16'hC001, MDB_rd=16'h4031 next cycle -> MAB=16'hC000, MW=0; next cycle if_rvalid=1, if_rdata=16'h4031.
REQ-043 Byte read d_addr=16'h0201, MDB_rd=16'hAB12 -> MAB=16'h0200; next cycle d_rdata=16'h00AB, d_rvalid=1, if_rvalid=0.
REQ-044 Byte write d_addr=16'h0203, d_wdata=16'h0055 -> MAB=16'h0203, MW=1, BW=1, MDB_wr=16'h5555; no rvalid follows.
REQ-045 if_req and d_req held high 5 cycles, STARVE_LIMIT=3 -> grant sequence D,D,D,F,D.
REQ-046 Word read d_addr=16'h0211 -> MAB=16'h0210, d_err=1 for one cycle, d_rvalid next cycle.
REQ-047 Read granted, then rst=1 the next cycle -> d_rvalid and if_rvalid stay 0; all bus outputs 0 until rst falls.
